renode_apb_manager: RTL and testbench

- Parametrised APB manager (requester) that turns a simple valid/ready command/response channel into APB3 transfers.
- Successor to the passive APB signal bundle: it adds the phase state machine, wait-state handling, error capture, and a bus-hang timeout.
- Sits between the Renode bus-bridge layer (command source) and APB subordinate peripherals in co-simulation.

---
 rtl/renode_apb_manager_pkg.sv | 27 ++
 rtl/renode_apb_timeout_counter.sv | 35 +++
 rtl/renode_apb_manager.sv | 175 +++++++++++++++++
 tb/tb_renode_apb_manager.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renode_apb_manager_pkg.sv
// Shared types for the Renode APB manager: phase state, response record, data-width legality check.
package renode_apb_pkg;

  localparam int unsigned ApbMaxDataW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [ApbMaxDataW-1:0] rdata;
    logic                   error;
    logic                   timeout;
  } apb_rsp_t;

  // APB4 strobes need a whole power-of-two number of byte lanes, so 24 is only legal for APB3.
  function automatic bit apb_data_width_ok(input int unsigned dw, input bit apb4);
    if (apb4) begin
      return (dw == 8) || (dw == 16) || (dw == 32);
    end
    return (dw == 8) || (dw == 16) || (dw == 24) || (dw == 32);
  endfunction

endpackage

// File: rtl/renode_apb_timeout_counter.sv
// Saturating ACCESS wait-state counter; expired flags the wait cycle that reaches TimeoutCycles.
module renode_apb_timeout_counter #(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic pclk,
  input  logic preset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TimeoutCycles == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
      localparam logic [CntW-1:0] CntMax   = CntW'(TimeoutCycles);
      localparam logic [CntW-1:0] LastWait = CntW'(TimeoutCycles - 1);

      logic [CntW-1:0] r_cnt;

      always_ff @(posedge pclk) begin
        if (preset || clr) begin
          r_cnt <= '0;
        end else if (en && (r_cnt != CntMax)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // Fires while the current stalled cycle is the TimeoutCycles-th one.
      assign expired = en && (r_cnt == LastWait);
    end
  endgenerate

endmodule

// File: rtl/renode_apb_manager.sv
// APB3 manager bridging a valid/ready command/response channel onto APB with wait states and timeout.
// Optional APB4 strobe/protection ports are enabled by defining RENODE_APB_MANAGER_APB4_EN.
module renode_apb_manager
  import renode_apb_pkg::*;
#(
  parameter int unsigned AddressWidth  = 20,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AddressWidth-1:0] req_addr,
  input  logic [DataWidth-1:0]    req_wdata,
`ifdef RENODE_APB_MANAGER_APB4_EN
  input  logic [DataWidth/8-1:0]  req_strb,
  input  logic [2:0]              req_prot,
  output logic [DataWidth/8-1:0]  pstrb,
  output logic [2:0]              pprot,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [AddressWidth-1:0] paddr,
  output logic                    pselx,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DataWidth-1:0]    pwdata,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

`ifdef RENODE_APB_MANAGER_APB4_EN
  localparam bit Apb4 = 1'b1;
`else
  localparam bit Apb4 = 1'b0;
`endif

  generate
    if (!apb_data_width_ok(DataWidth, Apb4)) begin : g_bad_width
      $error("renode_apb_manager: unsupported DataWidth %0d", DataWidth);
    end
  endgenerate

  apb_state_e               r_state;
  apb_state_e               w_state_nxt;
  apb_rsp_t                 w_rsp_nxt;
  logic                     w_req_fire;
  logic                     w_done;
  logic                     w_expired;
  logic                     w_cnt_clr;
  logic                     w_cnt_en;

  logic [AddressWidth-1:0]  r_paddr;
  logic                     r_psel;
  logic                     r_penable;
  logic                     r_pwrite;
  logic [DataWidth-1:0]     r_pwdata;
  logic                     r_rsp_valid;
  logic [DataWidth-1:0]     r_rsp_rdata;
  logic                     r_rsp_error;
  logic                     r_rsp_timeout;

  assign w_req_fire = req_valid && (r_state == IDLE);
  assign w_cnt_clr  = (r_state == SETUP);
  assign w_cnt_en   = (r_state == ACCESS) && !pready;
  assign w_done     = (r_state == ACCESS) && (pready || w_expired);

  renode_apb_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .pclk   (pclk),
    .preset (preset),
    .clr    (w_cnt_clr),
    .en     (w_cnt_en),
    .expired(w_expired)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (pready || w_expired) w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A real pready always wins over a coincident timeout.
  always_comb begin
    req_ready = 1'b0;
    w_rsp_nxt = '0;
    if (r_state == IDLE) begin
      req_ready = 1'b1;
    end
    if (pready) begin
      w_rsp_nxt.rdata = r_pwrite ? '0 : ApbMaxDataW'(prdata);
      w_rsp_nxt.error = pslverr;
    end else begin
      w_rsp_nxt.error   = 1'b1;
      w_rsp_nxt.timeout = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_psel      <= (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
      r_penable   <= (w_state_nxt == ACCESS);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_req_fire) begin
        r_paddr  <= req_addr;
        r_pwrite <= req_write;
        r_pwdata <= req_wdata;
      end
      if (w_done) begin
        r_rsp_rdata   <= w_rsp_nxt.rdata[DataWidth-1:0];
        r_rsp_error   <= w_rsp_nxt.error;
        r_rsp_timeout <= w_rsp_nxt.timeout;
      end
    end
  end

`ifdef RENODE_APB_MANAGER_APB4_EN
  logic [DataWidth/8-1:0] r_pstrb;
  logic [2:0]             r_pprot;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_pstrb <= '0;
      r_pprot <= '0;
    end else if (w_req_fire) begin
      r_pstrb <= req_write ? req_strb : '0;
      r_pprot <= req_prot;
    end
  end

  assign pstrb = r_pstrb;
  assign pprot = r_pprot;
`endif

  assign paddr       = r_paddr;
  assign pselx       = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_renode_apb_manager.sv
// Bench for renode_apb_manager: transaction-schedule model, APB responder, directed and random traffic.
module tb_renode_apb_manager;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          pselx;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
`ifdef RENODE_APB_MANAGER_APB4_EN
  logic [DW/8-1:0] req_strb = '1;
  logic [2:0]      req_prot = 3'd2;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
`endif

  always #5 pclk = ~pclk;

  renode_apb_manager #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef RENODE_APB_MANAGER_APB4_EN
    .req_strb   (req_strb),
    .req_prot   (req_prot),
    .pstrb      (pstrb),
    .pprot      (pprot),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .paddr      (paddr),
    .pselx      (pselx),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // Subordinate plan for the next command: wait cycles before pready, read data, error.
  int            plan_w = 0;
  logic [DW-1:0] plan_rd = '0;
  logic          plan_err = 1'b0;

  // Transaction-level model: one outstanding command with a known ACCESS length.
  bit            m_init = 0;
  bit            m_busy = 0;
  int            m_hs = 0;
  int            m_t = 0;
  int            m_w = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_write = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_prd = '0;
  logic          m_perr = 1'b0;
  logic [DW-1:0] m_rd = '0;
  logic          m_err = 1'b0;
  logic          m_to = 1'b0;

  int acc = 0;
  bit rr_rand = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (preset) begin
      m_init  = 1;
      m_busy  = 0;
      m_addr  = '0;
      m_write = 1'b0;
      m_wdata = '0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  = 1;
        m_hs    = cyc;
        m_addr  = req_addr;
        m_write = req_write;
        m_wdata = req_wdata;
        m_w     = plan_w;
        m_prd   = plan_rd;
        m_perr  = plan_err;
        if (plan_w < TO) begin
          m_t  = plan_w + 1;
          m_rd = req_write ? '0 : plan_rd;
          m_err = plan_err;
          m_to = 1'b0;
        end else begin
          m_t  = TO;
          m_rd = '0;
          m_err = 1'b1;
          m_to = 1'b1;
        end
      end
    end else if ((cyc - m_hs) >= 2 + m_t && rsp_ready) begin
      m_busy = 0;
    end
    cyc++;
  endtask

  task automatic respond();
    if (pselx === 1'b1 && penable === 1'b1) begin
      pready = (acc == m_w);
      acc++;
      if (pready) begin
        prdata  = m_prd;
        pslverr = m_perr;
      end else begin
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
    end else begin
      acc     = 0;
      pready  = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic compare();
    int d;
    bit e_sel, e_en, e_rv;
    if (!m_init) return;
    d     = cyc - m_hs;
    e_sel = m_busy && (d <= 1 + m_t);
    e_en  = m_busy && (d >= 2) && (d <= 1 + m_t);
    e_rv  = m_busy && (d >= 2 + m_t);
    chk("req_ready", 64'(req_ready), 64'(!m_busy));
    chk("pselx", 64'(pselx), 64'(e_sel));
    chk("penable", 64'(penable), 64'(e_en));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("paddr", 64'(paddr), 64'(m_addr));
    chk("pwrite", 64'(pwrite), 64'(m_write));
    if (m_busy && m_write) chk("pwdata", 64'(pwdata), 64'(m_wdata));
    if (e_rv) begin
      chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
      chk("rsp_error", 64'(rsp_error), 64'(m_err));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    respond();
    compare();
    if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // Returns at the negedge of the SETUP cycle of the accepted command.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int w, input logic [DW-1:0] rd, input logic err);
    int g = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    plan_w    = w;
    plan_rd   = rd;
    plan_err  = err;
    while (m_busy && g < 300) begin
      tick();
      g++;
    end
    if (g >= 300) chk("issue_bound", 64'(g), 64'(0));
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic wait_rsp(output int lat, output int nacc);
    lat  = 1;
    nacc = 0;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
      if (pselx === 1'b1 && penable === 1'b1) nacc++;
    end
    if (lat >= 60) chk("rsp_bound", 64'(lat), 64'(0));
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, nacc, g;

    repeat (3) tick();
    preset = 1'b0;
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_pselx", 64'(pselx), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_error", 64'(rsp_error), 64'(0));
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));

    // Zero-wait write: minimum latency.
    issue(1'b1, 20'h00010, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    chk("wr_setup_psel", 64'(pselx), 64'(1));
    chk("wr_setup_penable", 64'(penable), 64'(0));
    chk("wr_setup_paddr", 64'(paddr), 64'h00010);
    wait_rsp(lat, nacc);
    chk("wr_latency", 64'(lat), 64'(3));
    chk("wr_rsp_error", 64'(rsp_error), 64'(0));
    chk("wr_rsp_rdata", 64'(rsp_rdata), 64'(0));
    release_rsp();

    // Read with four wait states.
    issue(1'b0, 20'h00020, 32'h0, 4, 32'h12345678, 1'b0);
    wait_rsp(lat, nacc);
    chk("rd_wait_access_cycles", 64'(nacc), 64'(5));
    chk("rd_wait_latency", 64'(lat), 64'(7));
    chk("rd_wait_rdata", 64'(rsp_rdata), 64'h12345678);
    release_rsp();

    // Subordinate error on a read.
    issue(1'b0, 20'h00030, 32'h0, 0, 32'hFFFFFFFF, 1'b1);
    wait_rsp(lat, nacc);
    chk("slverr_error", 64'(rsp_error), 64'(1));
    chk("slverr_timeout", 64'(rsp_timeout), 64'(0));
    chk("slverr_rdata", 64'(rsp_rdata), 64'hFFFFFFFF);
    release_rsp();

    // Hung subordinate: terminated after TO ACCESS cycles.
    issue(1'b0, 20'h00040, 32'h0, 20, 32'h0BADF00D, 1'b0);
    wait_rsp(lat, nacc);
    chk("to_access_cycles", 64'(nacc), 64'(8));
    chk("to_pselx", 64'(pselx), 64'(0));
    chk("to_error", 64'(rsp_error), 64'(1));
    chk("to_timeout", 64'(rsp_timeout), 64'(1));
    chk("to_rdata", 64'(rsp_rdata), 64'(0));
    release_rsp();

    // pready on the last permitted cycle beats the timeout.
    issue(1'b0, 20'h00044, 32'h0, 7, 32'h55AA55AA, 1'b0);
    wait_rsp(lat, nacc);
    chk("edge_access_cycles", 64'(nacc), 64'(8));
    chk("edge_timeout", 64'(rsp_timeout), 64'(0));
    chk("edge_rdata", 64'(rsp_rdata), 64'h55AA55AA);
    release_rsp();

    // Response back-pressure with a second command waiting.
    issue(1'b0, 20'h00050, 32'h0, 0, 32'hA5A5A5A5, 1'b0);
    wait_rsp(lat, nacc);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 20'h00054;
    req_wdata = 32'hCAFEF00D;
    plan_w    = 1;
    plan_rd   = '0;
    plan_err  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'hA5A5A5A5);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_pselx", 64'(pselx), 64'(0));
    chk("bp_idle_req_ready", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    chk("bp_second_setup_psel", 64'(pselx), 64'(1));
    chk("bp_second_setup_penable", 64'(penable), 64'(0));
    chk("bp_second_paddr", 64'(paddr), 64'h00054);
    wait_rsp(lat, nacc);
    chk("bp_second_latency", 64'(lat), 64'(4));
    chk("bp_second_error", 64'(rsp_error), 64'(0));
    release_rsp();

    // Reset in the middle of a long ACCESS phase.
    issue(1'b0, 20'h00060, 32'h0, 10, 32'h00000001, 1'b0);
    nacc = 0;
    g = 0;
    while (nacc < 3 && g < 20) begin
      tick();
      g++;
      if (pselx === 1'b1 && penable === 1'b1) nacc++;
    end
    if (g >= 20) chk("mid_rst_bound", 64'(g), 64'(0));
    preset = 1'b1;
    tick();
    chk("mid_rst_pselx", 64'(pselx), 64'(0));
    chk("mid_rst_penable", 64'(penable), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    preset = 1'b0;
    tick();
    issue(1'b1, 20'h00070, 32'h13572468, 0, 32'h0, 1'b0);
    wait_rsp(lat, nacc);
    chk("post_rst_latency", 64'(lat), 64'(3));
    chk("post_rst_error", 64'(rsp_error), 64'(0));
    release_rsp();

    // Randomised traffic with random response back-pressure.
    rr_rand = 1;
    for (int n = 0; n < 60; n++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
            int'($urandom_range(0, 11)), $urandom, 1'($urandom_range(0, 1)));
      g = 0;
      while (m_busy && g < 200) begin
        tick();
        g++;
      end
      if (g >= 200) chk("rand_done_bound", 64'(g), 64'(0));
      repeat ($urandom_range(0, 2)) tick();
    end
    rr_rand   = 0;
    rsp_ready = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
